// File: rtl/adc_spi_pkg.sv
// Shared constants and the config-address to channel mapping for the SPI ADC responder.
package adc_spi_pkg;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_CFG_W  = 6;

  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // {O/S,S1,S0} address to physical channel: even channels first, then odd.
  function automatic logic [2:0] addr_to_chan(input logic [2:0] addr);
    logic [2:0] chan;
    case (addr)
      3'b000:  chan = 3'd0;
      3'b001:  chan = 3'd2;
      3'b010:  chan = 3'd4;
      3'b011:  chan = 3'd6;
      3'b100:  chan = 3'd1;
      3'b101:  chan = 3'd3;
      3'b110:  chan = 3'd5;
      3'b111:  chan = 3'd7;
      default: chan = 3'd0;
    endcase
    return chan;
  endfunction

endpackage

// File: rtl/adc_spi_responder_if.sv
// Serial bus between the joystick controller (master) and the ADC responder (slave).
interface adc_spi_responder_if;
  logic ADC_SCLK;
  logic ADC_CS_N;
  logic ADC_DIN;
  logic ADC_DOUT;

  modport master (output ADC_SCLK, output ADC_CS_N, output ADC_DIN, input ADC_DOUT);
  modport slave  (input ADC_SCLK, input ADC_CS_N, input ADC_DIN, output ADC_DOUT);
endinterface

// File: rtl/adc_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin, with rise/fall pulses from the last stage.
module adc_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   dly_r;

  // Synchronizer chain plus one delay flop used for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{RESET_VAL}};
      dly_r  <= RESET_VAL;
    end else begin
      sync_r[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      dly_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign level = sync_r[SYNC_STAGES-1];
  assign rise  = sync_r[SYNC_STAGES-1] & ~dly_r;
  assign fall  = ~sync_r[SYNC_STAGES-1] & dly_r;

endmodule

// File: rtl/adc_spi_responder.sv
// ADC-side SPI responder: decodes the 6-bit config word and returns the previous
// frame's conversion MSB first on ADC_DOUT.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CFG_W       = DEF_CFG_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLOCK,
  input  logic              RESET,
  adc_spi_responder_if.slave spi,
  input  logic [DATA_W-1:0] CH0,
  input  logic [DATA_W-1:0] CH1,
  input  logic [DATA_W-1:0] CH2,
  input  logic [DATA_W-1:0] CH3,
  input  logic [DATA_W-1:0] CH4,
  input  logic [DATA_W-1:0] CH5,
  input  logic [DATA_W-1:0] CH6,
  input  logic [DATA_W-1:0] CH7,
  output logic              FRAME_DONE,
  output logic              CFG_ERR
);

  localparam int CNT_W = $clog2(CFG_W + 1);

  logic sclk_rise_s, sclk_fall_s, sclk_level_unused;
  logic cs_rise_s, cs_fall_s, cs_level_unused;
  logic din_s, din_rise_unused, din_fall_unused;

  state_t            state_r, state_next_s;
  logic [DATA_W-1:0] sr_r, pending_r, pending_next_s;
  logic [CFG_W-1:0]  cfg_r;
  logic [CNT_W-1:0]  cfg_cnt_r;
  logic              dout_r, frame_done_r, cfg_err_r;
  logic              load_s, cfg_shift_s, sr_shift_s, frame_end_s, err_s;
  logic [2:0]        addr_s;
  logic [1:0]        cfg_mode_unused;
  logic [DATA_W-1:0] ch_s [8];

  adc_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(CLOCK), .rst(RESET), .d(spi.ADC_SCLK),
    .level(sclk_level_unused), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  adc_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(CLOCK), .rst(RESET), .d(spi.ADC_CS_N),
    .level(cs_level_unused), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  adc_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
    .clk(CLOCK), .rst(RESET), .d(spi.ADC_DIN),
    .level(din_s), .rise(din_rise_unused), .fall(din_fall_unused)
  );

  assign ch_s[0] = CH0;
  assign ch_s[1] = CH1;
  assign ch_s[2] = CH2;
  assign ch_s[3] = CH3;
  assign ch_s[4] = CH4;
  assign ch_s[5] = CH5;
  assign ch_s[6] = CH6;
  assign ch_s[7] = CH7;

  assign addr_s          = {cfg_r[CFG_OS], cfg_r[CFG_S1], cfg_r[CFG_S0]};
  // UNI and SLP are accepted on the wire but have no effect on this model.
  assign cfg_mode_unused = {cfg_r[CFG_UNI], cfg_r[CFG_SLP]};

  // Frame state register.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: CS_N fall opens a frame, CS_N rise closes it from any bit.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cs_fall_s) state_next_s = ST_ACTIVE;
        else           state_next_s = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (cs_rise_s) state_next_s = ST_IDLE;
        else           state_next_s = ST_ACTIVE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Per-cycle actions; CS_N rise wins over SCLK edges, and edges in IDLE are dropped.
  always_comb begin
    load_s      = 1'b0;
    cfg_shift_s = 1'b0;
    sr_shift_s  = 1'b0;
    frame_end_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        load_s = cs_fall_s;
      end
      ST_ACTIVE: begin
        if (cs_rise_s) begin
          frame_end_s = 1'b1;
        end else begin
          cfg_shift_s = sclk_rise_s && (cfg_cnt_r < CNT_W'(CFG_W));
          sr_shift_s  = sclk_fall_s;
        end
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // Config evaluation at frame end: short or differential requests flag an error.
  always_comb begin
    pending_next_s = pending_r;
    err_s          = 1'b0;
    if (cfg_cnt_r != CNT_W'(CFG_W)) begin
      err_s          = 1'b1;
      pending_next_s = pending_r;
    end else if (!cfg_r[CFG_SD]) begin
      err_s          = 1'b1;
      pending_next_s = '0;
    end else begin
      err_s          = 1'b0;
      pending_next_s = ch_s[addr_to_chan(addr_s)];
    end
  end

  // Shift registers, pending conversion and registered outputs.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      sr_r         <= '0;
      pending_r    <= '0;
      cfg_r        <= '0;
      cfg_cnt_r    <= '0;
      dout_r       <= 1'b0;
      frame_done_r <= 1'b0;
      cfg_err_r    <= 1'b0;
    end else begin
      frame_done_r <= frame_end_s;
      cfg_err_r    <= frame_end_s & err_s;
      if (load_s) begin
        sr_r      <= pending_r;
        dout_r    <= pending_r[DATA_W-1];
        cfg_r     <= '0;
        cfg_cnt_r <= '0;
      end else if (frame_end_s) begin
        pending_r <= pending_next_s;
        sr_r      <= '0;
        dout_r    <= 1'b0;
      end else begin
        if (cfg_shift_s) begin
          cfg_r     <= {cfg_r[CFG_W-2:0], din_s};
          cfg_cnt_r <= cfg_cnt_r + CNT_W'(1);
        end
        // Zero fill keeps DOUT low once all DATA_W bits have been sent.
        if (sr_shift_s) begin
          sr_r   <= {sr_r[DATA_W-2:0], 1'b0};
          dout_r <= sr_r[DATA_W-2];
        end
      end
    end
  end

  assign spi.ADC_DOUT = dout_r;
  assign FRAME_DONE   = frame_done_r;
  assign CFG_ERR      = cfg_err_r;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench: drives SPI frames as the controller and scoreboards returned data and pulses.
module tb_adc_spi_responder;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] ch [8];
  logic        frame_done, cfg_err;
  int          fd_cnt = 0;
  int          ce_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  logic [11:0] model_pending;
  exp_t        exp_q [$];

  always #5 clk = ~clk;

  adc_spi_responder_if spi();

  adc_spi_responder dut (
    .CLOCK(clk), .RESET(rst), .spi(spi),
    .CH0(ch[0]), .CH1(ch[1]), .CH2(ch[2]), .CH3(ch[3]),
    .CH4(ch[4]), .CH5(ch[5]), .CH6(ch[6]), .CH7(ch[7]),
    .FRAME_DONE(frame_done), .CFG_ERR(cfg_err)
  );

  // Pulse counters, sampled on the inactive edge.
  always @(negedge clk) begin
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (cfg_err)    ce_cnt <= ce_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sclk_cycle(input logic din);
    spi.ADC_DIN = din;
    repeat (3) @(negedge clk);
    spi.ADC_SCLK = 1'b1;
    repeat (6) @(negedge clk);
    spi.ADC_SCLK = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic run_frame(input logic [5:0] cfg, input int nsclk, input string tag);
    exp_t        e;
    logic [15:0] rx;
    logic [11:0] nxt;
    logic        err;
    logic        bit_v;
    int          fd0, ce0, idx;
    e.nbits = nsclk;
    e.bits  = {model_pending, 4'h0} >> (16 - nsclk);
    if (nsclk < 6) begin
      err = 1'b1;
      nxt = model_pending;
    end else if (!cfg[5]) begin
      err = 1'b1;
      nxt = 12'h000;
    end else begin
      err = 1'b0;
      idx = int'(cfg[3:2]) * 2 + int'(cfg[4]);
      nxt = ch[idx];
    end
    e.err = err;
    exp_q.push_back(e);

    fd0 = fd_cnt;
    ce0 = ce_cnt;
    rx  = 16'h0000;
    spi.ADC_CS_N = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nsclk; i++) begin
      rx = {rx[14:0], spi.ADC_DOUT};
      if (i < 6) bit_v = cfg[5-i];
      else       bit_v = 1'b1;
      sclk_cycle(bit_v);
    end
    spi.ADC_CS_N = 1'b1;
    spi.ADC_DIN  = 1'b0;
    repeat (8) @(negedge clk);

    e = exp_q.pop_front();
    check_val({tag, "_data"}, 32'(rx), 32'(e.bits));
    check_val({tag, "_frame_done"}, fd_cnt - fd0, 32'd1);
    check_val({tag, "_cfg_err"}, ce_cnt - ce0, 32'(e.err));
    check_val({tag, "_idle_dout"}, 32'(spi.ADC_DOUT), 32'd0);
    model_pending = nxt;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    spi.ADC_CS_N = 1'b1;
    spi.ADC_SCLK = 1'b0;
    spi.ADC_DIN  = 1'b0;
    for (int i = 0; i < 8; i++) ch[i] = 12'h000;
    model_pending = 12'h000;
    repeat (3) @(negedge clk);
    check_val("reset_dout", 32'(spi.ADC_DOUT), 32'd0);
    check_val("reset_frame_done", 32'(frame_done), 32'd0);
    check_val("reset_cfg_err", 32'(cfg_err), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Address 001 selects CH2; its value appears one frame later.
    ch[2] = 12'hABC;
    run_frame(6'b100110, 12, "first");
    run_frame(6'b100000, 12, "second");

    for (int n = 0; n < 8; n++) ch[n] = 12'h100 + 12'(n);
    for (int a = 0; a < 8; a++) begin
      logic [2:0] a_v;
      a_v = 3'(a);
      run_frame({1'b1, a_v, 2'b00}, 12, "sweep");
    end

    run_frame(6'b100000, 3, "short");
    ch[0] = 12'hFFF;
    run_frame(6'b011100, 12, "diff");
    run_frame(6'b101000, 16, "long");
    run_frame(6'b110000, 12, "after_long");

    // Prime 0x555, then reset in the middle of the frame returning it.
    ch[0] = 12'h555;
    run_frame(6'b100000, 12, "prime");
    spi.ADC_CS_N = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 5; i++) sclk_cycle(1'b1);
    check_val("mid_frame_dout", 32'(spi.ADC_DOUT), 32'(model_pending[6]));
    rst = 1'b1;
    #1;
    check_val("async_reset_dout", 32'(spi.ADC_DOUT), 32'd0);
    spi.ADC_CS_N = 1'b1;
    spi.ADC_SCLK = 1'b0;
    spi.ADC_DIN  = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    model_pending = 12'h000;
    run_frame(6'b100000, 12, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
